// File: rtl/sequenciador_pkg.sv
// Shared definitions for the move sequencer: FSM state encoding and the
// 3-bit move codes exchanged with the servo manager.
package sequenciador_pkg;

    localparam int LARGURA_MOVE = 3;

    typedef enum logic [2:0] {
        OCIOSO  = 3'd0,
        INICIA  = 3'd1,
        AGUARDA = 3'd2,
        PROXIMO = 3'd3,
        FIM     = 3'd4,
        ERRO    = 3'd5
    } estado_t;

    // Move codes understood by the servo manager (one per cube face, plus a whole-cube turn).
    localparam logic [LARGURA_MOVE-1:0] MOVE_U    = 3'd0;
    localparam logic [LARGURA_MOVE-1:0] MOVE_D    = 3'd1;
    localparam logic [LARGURA_MOVE-1:0] MOVE_L    = 3'd2;
    localparam logic [LARGURA_MOVE-1:0] MOVE_R    = 3'd3;
    localparam logic [LARGURA_MOVE-1:0] MOVE_F    = 3'd4;
    localparam logic [LARGURA_MOVE-1:0] MOVE_B    = 3'd5;
    localparam logic [LARGURA_MOVE-1:0] MOVE_GIRA = 3'd6;

    localparam logic [LARGURA_MOVE-1:0] CODIGO_RESERVADO = 3'b111;

    function automatic logic codigo_valido(input logic [LARGURA_MOVE-1:0] codigo);
        return codigo != CODIGO_RESERVADO;
    endfunction

endpackage

// File: rtl/memoria_movimentos.sv
// Move storage: synchronous write, asynchronous read, no reset (contents
// are meaningless until written).
module memoria_movimentos
    import sequenciador_pkg::*;
#(
    parameter int PROFUNDIDADE = 64,
    parameter int LARGURA_END  = 6
) (
    input  logic                    clock,
    input  logic                    escreve,
    input  logic [LARGURA_END-1:0]  end_escrita,
    input  logic [LARGURA_MOVE-1:0] dado_escrita,
    input  logic [LARGURA_END-1:0]  end_leitura,
    output logic [LARGURA_MOVE-1:0] dado_leitura
);

    logic [LARGURA_MOVE-1:0] mem [PROFUNDIDADE];

    always_ff @(posedge clock) begin
        if (escreve) mem[end_escrita] <= dado_escrita;
    end

    assign dado_leitura = mem[end_leitura];

endmodule

// File: rtl/sequenciador_movimentos.sv
// Stores a sequence of move codes and plays it to the servo manager one
// move at a time, with a per-move stall watchdog and a sticky error flag.
module sequenciador_movimentos
    import sequenciador_pkg::*;
#(
    parameter int PROFUNDIDADE   = 64,
    parameter int LARGURA_END    = 6,
    parameter int TIMEOUT_CICLOS = 50_000_000
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   carrega,
    input  logic [2:0]             dado_move,
    input  logic                   limpa,
    input  logic                   executar,
    input  logic                   pronto_servos,
    output logic                   iniciar_servos,
    output logic [2:0]             move_servos,
    output logic                   ocupado,
    output logic                   fim,
    output logic                   erro,
    output logic [LARGURA_END:0]   num_moves,
    output logic [LARGURA_END-1:0] indice,
    output logic [2:0]             db_estado
);

    localparam int WD_W       = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam int LIMITE_INT = TIMEOUT_CICLOS - 2;
    // Leaving AGUARDA when the counter would reach TIMEOUT_CICLOS-1 puts ERRO
    // exactly TIMEOUT_CICLOS cycles after the start pulse.
    localparam logic [WD_W-1:0]      WD_LIMITE = LIMITE_INT[WD_W-1:0];
    localparam logic [LARGURA_END:0] CHEIO     = PROFUNDIDADE[LARGURA_END:0];

    estado_t                 estado, prox_estado;
    logic [LARGURA_END:0]    cnt;
    logic [LARGURA_END-1:0]  idx, idx_prox;
    logic [WD_W-1:0]         wd;
    logic [2:0]              move_q, mem_rdata;
    logic                    erro_q;
    logic                    limpar, escrever, rejeitar, ultimo;

    assign limpar   = limpa && (estado == OCIOSO || estado == ERRO);
    assign escrever = carrega && !limpa && estado == OCIOSO
                      && codigo_valido(dado_move) && cnt != CHEIO;
    // Any load that is neither overridden by limpa nor stored is an error.
    assign rejeitar = carrega && !limpar && !escrever;
    assign ultimo   = ({1'b0, idx} == cnt - 1'b1);

    memoria_movimentos #(
        .PROFUNDIDADE (PROFUNDIDADE),
        .LARGURA_END  (LARGURA_END)
    ) u_mem (
        .clock        (clock),
        .escreve      (escrever),
        .end_escrita  (cnt[LARGURA_END-1:0]),
        .dado_escrita (dado_move),
        .end_leitura  (idx_prox),
        .dado_leitura (mem_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) estado <= OCIOSO;
        else       estado <= prox_estado;
    end

    always_comb begin
        prox_estado = estado;
        idx_prox    = idx;
        if (limpar) begin
            prox_estado = OCIOSO;
            idx_prox    = '0;
        end else begin
            case (estado)
                OCIOSO: if (executar) begin
                    idx_prox    = '0;
                    prox_estado = (cnt == '0) ? FIM : INICIA;
                end
                INICIA: prox_estado = AGUARDA;
                AGUARDA: begin
                    if (pronto_servos)         prox_estado = PROXIMO;
                    else if (wd == WD_LIMITE)  prox_estado = ERRO;
                end
                PROXIMO: begin
                    if (ultimo) prox_estado = FIM;
                    else begin
                        idx_prox    = idx + 1'b1;
                        prox_estado = INICIA;
                    end
                end
                FIM: begin
                    idx_prox    = '0;
                    prox_estado = OCIOSO;
                end
                ERRO:    prox_estado = ERRO;
                default: prox_estado = OCIOSO;
            endcase
        end
    end

    always_comb begin
        iniciar_servos = 1'b0;
        ocupado        = 1'b0;
        fim            = 1'b0;
        case (estado)
            INICIA: begin
                iniciar_servos = 1'b1;
                ocupado        = 1'b1;
            end
            AGUARDA, PROXIMO: ocupado = 1'b1;
            FIM:              fim     = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt    <= '0;
            idx    <= '0;
            wd     <= '0;
            move_q <= '0;
            erro_q <= 1'b0;
        end else begin
            idx <= idx_prox;

            if (limpar)        cnt <= '0;
            else if (escrever) cnt <= cnt + 1'b1;

            if (estado == INICIA)       wd <= '0;
            else if (estado == AGUARDA) wd <= wd + 1'b1;

            if (limpar)
                erro_q <= 1'b0;
            else if (rejeitar || (estado == AGUARDA && prox_estado == ERRO))
                erro_q <= 1'b1;

            // Code is captured on entry to INICIA so it is valid with the start pulse.
            case (prox_estado)
                INICIA:           move_q <= mem_rdata;
                AGUARDA, PROXIMO: move_q <= move_q;
                default:          move_q <= '0;
            endcase
        end
    end

    assign move_servos = move_q;
    assign erro        = erro_q;
    assign num_moves   = cnt;
    assign indice      = idx;
    assign db_estado   = estado;

endmodule

// File: tb/tb_sequenciador_movimentos.sv
// Bench for sequenciador_movimentos: directed scenarios with literal
// expectations plus random traffic checked every cycle against a queue model.
module tb_sequenciador_movimentos;

    localparam int PROF = 64;
    localparam int LEND = 6;
    localparam int TMO  = 20;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            carrega = 1'b0, limpa = 1'b0, executar = 1'b0, pronto_servos = 1'b0;
    logic [2:0]      dado_move = 3'd0;
    logic            iniciar_servos, ocupado, fim, erro;
    logic [2:0]      move_servos, db_estado;
    logic [LEND:0]   num_moves;
    logic [LEND-1:0] indice;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model: stored sequence as a queue, phase numbered as the documented state codes.
    logic [2:0] m_seq[$];
    int         m_fase = 0;
    int         m_idx  = 0;
    int         m_esp  = 0;
    logic [2:0] m_move = 3'd0;
    logic       m_erro = 1'b0;

    logic [2:0] vistos[$];

    sequenciador_movimentos #(
        .PROFUNDIDADE   (PROF),
        .LARGURA_END    (LEND),
        .TIMEOUT_CICLOS (TMO)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .carrega        (carrega),
        .dado_move      (dado_move),
        .limpa          (limpa),
        .executar       (executar),
        .pronto_servos  (pronto_servos),
        .iniciar_servos (iniciar_servos),
        .move_servos    (move_servos),
        .ocupado        (ocupado),
        .fim            (fim),
        .erro           (erro),
        .num_moves      (num_moves),
        .indice         (indice),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_tests++;
        if (atual !== esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    task automatic modelo_passo();
        int n, nf, ni, esp;
        logic ne;
        logic [2:0] nm;
        n = m_seq.size(); nf = m_fase; ni = m_idx; esp = m_esp; ne = m_erro;
        if (reset) begin
            m_seq.delete(); nf = 0; ni = 0; esp = 0; ne = 1'b0;
        end else if (limpa && (m_fase == 0 || m_fase == 5)) begin
            m_seq.delete(); nf = 0; ni = 0; ne = 1'b0;
        end else begin
            if (carrega) begin
                if (m_fase == 0 && dado_move != 3'd7 && n < PROF) m_seq.push_back(dado_move);
                else ne = 1'b1;
            end
            case (m_fase)
                0: if (executar) begin ni = 0; nf = (n == 0) ? 4 : 1; end
                1: begin nf = 2; esp = 0; end
                2: begin
                    // at most TMO-1 waiting cycles: ERRO lands TMO cycles after the start pulse
                    if (pronto_servos) nf = 3;
                    else if (esp + 1 == TMO - 1) begin nf = 5; ne = 1'b1; end
                    esp = esp + 1;
                end
                3: if (m_idx == n - 1) nf = 4; else begin ni = m_idx + 1; nf = 1; end
                4: begin nf = 0; ni = 0; end
                default: ;
            endcase
        end
        if (nf == 1)                nm = m_seq[ni];
        else if (nf == 2 || nf == 3) nm = m_move;
        else                        nm = 3'd0;
        m_fase <= nf; m_idx <= ni; m_esp <= esp; m_erro <= ne; m_move <= nm;
    endtask

    task automatic compara();
        chk("iniciar_servos", 32'(iniciar_servos), 32'(m_fase == 1));
        chk("ocupado",        32'(ocupado),        32'(m_fase >= 1 && m_fase <= 3));
        chk("fim",            32'(fim),            32'(m_fase == 4));
        chk("erro",           32'(erro),           32'(m_erro));
        chk("num_moves",      32'(num_moves),      m_seq.size());
        chk("indice",         32'(indice),         m_idx);
        chk("move_servos",    32'(move_servos),    32'(m_move));
        chk("db_estado",      32'(db_estado),      m_fase);
    endtask

    always @(posedge clock) modelo_passo();
    always @(negedge clock) if (chk_en) compara();

    task automatic passo(input logic c, input logic [2:0] d, input logic l, input logic e, input logic p);
        carrega = c; dado_move = d; limpa = l; executar = e; pronto_servos = p;
        @(negedge clock);
    endtask

    task automatic chk_zero(input string pre);
        chk({pre, "_iniciar"}, 32'(iniciar_servos), 0);
        chk({pre, "_ocupado"}, 32'(ocupado), 0);
        chk({pre, "_fim"},     32'(fim), 0);
        chk({pre, "_erro"},    32'(erro), 0);
        chk({pre, "_num"},     32'(num_moves), 0);
        chk({pre, "_indice"},  32'(indice), 0);
        chk({pre, "_move"},    32'(move_servos), 0);
        chk({pre, "_estado"},  32'(db_estado), 0);
    endtask

    // Servo-manager stand-in: answers every start pulse `atraso` cycles later.
    task automatic servo(input int atraso, input int budget, output bit fim_ok);
        int cd;
        logic p;
        cd = -1; fim_ok = 1'b0; vistos.delete();
        for (int k = 0; k < budget; k++) begin
            if (fim) begin fim_ok = 1'b1; break; end
            if (iniciar_servos) begin vistos.push_back(move_servos); cd = atraso; end
            p = (cd == 0);
            if (cd >= 0) cd--;
            passo(1'b0, 3'd0, 1'b0, 1'b0, p);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        int t, ndif;
        bit ok;
        logic [2:0] esp_a[3];
        logic [2:0] cod[PROF];
        esp_a = '{3'd3, 3'd1, 3'd5};

        @(negedge clock);
        reset = 1'b1;
        passo(0, 0, 0, 0, 0); passo(0, 0, 0, 0, 0);
        chk_zero("reset");
        reset = 1'b0;
        chk_en = 1'b1;

        // reserved code rejected, pronto ignored while idle, limpa beats carrega
        passo(1, 3'd2, 0, 0, 0); passo(1, 3'd6, 0, 0, 0); passo(1, 3'd7, 0, 0, 0);
        chk("reservado_erro", 32'(erro), 1);
        chk("reservado_num", 32'(num_moves), 2);
        passo(0, 0, 0, 0, 1);
        chk("pronto_ocioso", 32'(db_estado), 0);
        passo(1, 3'd4, 1, 0, 0);
        chk("limpa_vence_num", 32'(num_moves), 0);
        chk("limpa_vence_erro", 32'(erro), 0);

        // three-move sequence, servo answers after 10 cycles
        passo(1, 3'd3, 0, 0, 0); passo(1, 3'd1, 0, 0, 0); passo(1, 3'd5, 0, 0, 0);
        chk("seqA_num", 32'(num_moves), 3);
        passo(0, 0, 0, 1, 0);
        chk("seqA_lat_iniciar", 32'(iniciar_servos), 1);
        chk("seqA_lat_move", 32'(move_servos), 3);
        servo(10, 200, ok);
        chk("seqA_fim", 32'(ok), 1);
        chk("seqA_qtd", vistos.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < vistos.size()) chk("seqA_move", 32'(vistos[i]), 32'(esp_a[i]));
        passo(0, 0, 0, 0, 0);
        chk("seqA_ocupado", 32'(ocupado), 0);
        chk("seqA_indice", 32'(indice), 0);
        chk("seqA_fim_pulso", 32'(fim), 0);

        // empty sequence
        passo(0, 0, 1, 0, 0);
        passo(0, 0, 0, 1, 0);
        chk("vazio_fim", 32'(fim), 1);
        chk("vazio_iniciar", 32'(iniciar_servos), 0);
        passo(0, 0, 0, 0, 0);
        chk("vazio_ocioso", 32'(db_estado), 0);

        // fill to capacity, overflow, replay all, clear
        for (int i = 0; i < PROF; i++) begin
            cod[i] = 3'($urandom_range(0, 6));
            passo(1, cod[i], 0, 0, 0);
        end
        chk("cheio_num", 32'(num_moves), PROF);
        chk("cheio_sem_erro", 32'(erro), 0);
        passo(1, 3'd1, 0, 0, 0);
        chk("excesso_num", 32'(num_moves), PROF);
        chk("excesso_erro", 32'(erro), 1);
        passo(0, 0, 0, 1, 0);
        servo(1 + $urandom_range(0, 3), 2000, ok);
        chk("cheio_fim", 32'(ok), 1);
        chk("cheio_qtd", vistos.size(), PROF);
        ndif = 0;
        for (int i = 0; i < PROF; i++)
            if (i >= vistos.size() || vistos[i] !== cod[i]) ndif++;
        chk("cheio_moves_diferentes", ndif, 0);
        passo(0, 0, 0, 0, 0);
        passo(0, 0, 1, 0, 0);
        chk("limpa_num", 32'(num_moves), 0);
        chk("limpa_erro", 32'(erro), 0);

        // watchdog: no answer from the servo
        passo(1, 3'd4, 0, 0, 0);
        passo(0, 0, 0, 1, 0);
        chk("tmo_iniciar", 32'(iniciar_servos), 1);
        t = 0;
        do begin passo(0, 0, 0, 0, 0); t++; end while (db_estado != 3'd5 && t < 100);
        chk("tmo_ciclos", t, TMO);
        chk("tmo_erro", 32'(erro), 1);
        passo(0, 0, 0, 1, 0);
        chk("erro_ignora_exec", 32'(db_estado), 5);
        chk("erro_sem_iniciar", 32'(iniciar_servos), 0);
        chk("erro_ocupado", 32'(ocupado), 0);
        passo(0, 0, 0, 0, 1);
        chk("erro_ignora_pronto", 32'(db_estado), 5);
        passo(0, 0, 1, 0, 0);
        chk("erro_limpa_estado", 32'(db_estado), 0);
        chk("erro_limpa_flag", 32'(erro), 0);

        // reset while waiting on move 2 of 4
        passo(1, 3'd2, 0, 0, 0); passo(1, 3'd0, 0, 0, 0);
        passo(1, 3'd6, 0, 0, 0); passo(1, 3'd4, 0, 0, 0);
        passo(0, 0, 0, 1, 0);
        passo(0, 0, 0, 0, 0);
        passo(0, 0, 0, 0, 1);
        passo(0, 0, 0, 0, 0);
        chk("meio_iniciar2", 32'(iniciar_servos), 1);
        chk("meio_indice", 32'(indice), 1);
        chk("meio_move", 32'(move_servos), 0);
        passo(0, 0, 0, 0, 0);
        chk("meio_aguarda", 32'(db_estado), 2);
        reset = 1'b1;
        passo(0, 0, 0, 0, 0);
        chk_zero("reset_meio");
        reset = 1'b0;

        // random traffic, checked every cycle by the model
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            passo($urandom_range(0, 99) < 15, 3'($urandom_range(0, 7)),
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 10,
                  $urandom_range(0, 99) < 25);
        end
        reset = 1'b0;
        passo(0, 0, 0, 0, 0);
        passo(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
